// File: rtl/cpu_trace_emitter.sv
// cpu_trace_emitter: serialises one register/memory write record into an ASCII character stream.
// Define TRACE_SPACES_EN to emit the three separator spaces; otherwise the compact form is produced.
module cpu_trace_emitter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        kind,
    input  logic [15:0] time_bcd,
    input  logic [31:0] pc,
    input  logic [4:0]  reg_id,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic [7:0]  char,
    output logic        char_valid,
    output logic        busy,
    output logic        done
);
`ifdef TRACE_SPACES_EN
    localparam bit SPACES = 1'b1;
`else
    localparam bit SPACES = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SP1, S_KIND,
        S_ID, S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_HASH
    } state_t;

    state_t      state, nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        k_q;
    logic [15:0] t_q;
    logic [31:0] p_q, a_q, d_q;
    logic [4:0]  r_q;
    logic [1:0]  t_top, tens;
    logic [3:0]  ones;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
    endfunction

    // BCD digits above 9 saturate to '9'
    function automatic logic [7:0] dec(input logic [3:0] n);
        return 8'h30 + (n > 4'd9 ? 8'd9 : {4'h0, n});
    endfunction

    always_comb begin
        t_top = t_q[15:12] != 4'd0 ? 2'd3 : t_q[11:8] != 4'd0 ? 2'd2 : t_q[7:4] != 4'd0 ? 2'd1 : 2'd0;
        tens  = r_q >= 5'd30 ? 2'd3 : r_q >= 5'd20 ? 2'd2 : r_q >= 5'd10 ? 2'd1 : 2'd0;
        ones  = 4'(r_q - 5'd10 * {3'b000, tens});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 3'd0;
            k_q   <= 1'b0;
            t_q   <= 16'h0;
            p_q   <= 32'h0;
            r_q   <= 5'd0;
            a_q   <= 32'h0;
            d_q   <= 32'h0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
            if (state == S_IDLE && start) begin
                k_q <= kind;
                t_q <= time_bcd;
                p_q <= pc;
                r_q <= reg_id;
                a_q <= addr;
                d_q <= data;
            end
        end
    end

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        case (state)
            S_IDLE:  nxt = start ? S_CARET : S_IDLE;
            S_CARET: begin nxt = S_TIME; cnt_nxt = {1'b0, t_top}; end
            S_TIME:  if (cnt == 3'd0) nxt = S_AT; else cnt_nxt = cnt - 3'd1;
            S_AT:    begin nxt = S_PC; cnt_nxt = 3'd7; end
            S_PC:    if (cnt == 3'd0) nxt = S_COLON; else cnt_nxt = cnt - 3'd1;
            S_COLON: nxt = SPACES ? S_SP1 : S_KIND;
            S_SP1:   nxt = S_KIND;
            S_KIND:  begin nxt = S_ID; cnt_nxt = k_q ? 3'd7 : (r_q >= 5'd10 ? 3'd1 : 3'd0); end
            S_ID:    if (cnt == 3'd0) nxt = SPACES ? S_SP2 : S_LT; else cnt_nxt = cnt - 3'd1;
            S_SP2:   nxt = S_LT;
            S_LT:    nxt = S_EQ;
            S_EQ:    begin nxt = SPACES ? S_SP3 : S_DATA; cnt_nxt = 3'd7; end
            S_SP3:   begin nxt = S_DATA; cnt_nxt = 3'd7; end
            S_DATA:  if (cnt == 3'd0) nxt = S_HASH; else cnt_nxt = cnt - 3'd1;
            S_HASH:  begin nxt = S_IDLE; cnt_nxt = 3'd0; end
            default: begin nxt = S_IDLE; cnt_nxt = 3'd0; end
        endcase
    end

    always_comb begin
        char = 8'h00;
        case (state)
            S_CARET:             char = "^";
            S_TIME:              char = dec(t_q[{cnt[1:0], 2'b00} +: 4]);
            S_AT:                char = "@";
            S_PC:                char = hex(p_q[{cnt, 2'b00} +: 4]);
            S_COLON:             char = ":";
            S_SP1, S_SP2, S_SP3: char = 8'h20;
            S_KIND:              char = k_q ? "*" : "$";
            S_ID:                char = k_q ? hex(a_q[{cnt, 2'b00} +: 4]) : dec(cnt[0] ? {2'b00, tens} : ones);
            S_LT:                char = "<";
            S_EQ:                char = "=";
            S_DATA:              char = hex(d_q[{cnt, 2'b00} +: 4]);
            S_HASH:              char = "#";
            default:             char = 8'h00;
        endcase
        char_valid = state != S_IDLE;
        busy       = state != S_IDLE;
        done       = state == S_HASH;
    end
endmodule

// File: tb/tb_cpu_trace_emitter.sv
// tb_cpu_trace_emitter: directed and randomized records checked against a string-building reference model.
module tb_cpu_trace_emitter;
`ifdef TRACE_SPACES_EN
    localparam bit SPACES = 1'b1;
`else
    localparam bit SPACES = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, kind;
    logic [15:0] time_bcd;
    logic [31:0] pc, addr, data;
    logic [4:0]  reg_id;
    logic [7:0]  char;
    logic        char_valid, busy, done;
    int          checks = 0;
    int          failures = 0;

    cpu_trace_emitter dut (
        .clk(clk), .reset(reset), .start(start), .kind(kind), .time_bcd(time_bcd),
        .pc(pc), .reg_id(reg_id), .addr(addr), .data(data),
        .char(char), .char_valid(char_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic string model(input bit k, input logic [15:0] t, input logic [31:0] p,
                                    input logic [4:0] r, input logic [31:0] a, input logic [31:0] d);
        string s, sp;
        bit lead;
        int n;
        lead = 1'b1;
        sp = SPACES ? " " : "";
        s = "^";
        for (int i = 3; i >= 0; i--) begin
            n = int'((t >> (4 * i)) & 16'hf);
            if (n != 0 || !lead || i == 0) begin
                lead = 1'b0;
                s = {s, $sformatf("%0d", n > 9 ? 9 : n)};
            end
        end
        s = {s, "@", $sformatf("%08h", p), ":", sp};
        s = {s, k ? $sformatf("*%08h", a) : $sformatf("$%0d", r), sp, "<=", sp, $sformatf("%08h", d), "#"};
        return s;
    endfunction

    task automatic check_str(input string tag, input string got, input string exp);
        checks++;
        assert (got == exp) else begin
            failures++;
            $error("FAIL %s: got \"%s\" expected \"%s\"", tag, got, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one record, scrambles inputs while it runs, and checks the full stream.
    task automatic run(input string tag, input bit k, input logic [15:0] t, input logic [31:0] p,
                       input logic [4:0] r, input logic [31:0] a, input logic [31:0] d, output string got);
        string exp;
        int dn;
        bit on_hash;
        exp = model(k, t, p, r, a, d);
        kind = k; time_bcd = t; pc = p; reg_id = r; addr = a; data = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        got = "";
        dn = 0;
        on_hash = 1'b1;
        for (int i = 0; i < 64 && char_valid; i++) begin
            got = {got, $sformatf("%c", char)};
            if (done) begin
                dn++;
                if (char != 8'h23) on_hash = 1'b0;
            end
            kind = 1'($urandom); time_bcd = 16'($urandom); pc = $urandom;
            reg_id = 5'($urandom); addr = $urandom; data = $urandom; start = 1'($urandom);
            tick();
        end
        start = 1'b0;
        check_str({tag, " stream"}, got, exp);
        check_val({tag, " done_count"}, dn, 1);
        check_val({tag, " done_on_hash"}, {31'b0, on_hash}, 1);
        check_val({tag, " busy_after"}, {31'b0, busy}, 0);
    endtask

    initial begin
        string got;
        int carets, idles, dones, len;
        logic [15:0] tr;
        reset = 1'b1; start = 1'b0; kind = 1'b0; time_bcd = 16'h0;
        pc = 32'h0; reg_id = 5'd0; addr = 32'h0; data = 32'h0;
        repeat (3) tick();
        check_val("rst char", {24'b0, char}, 0);
        check_val("rst char_valid", {31'b0, char_valid}, 0);
        check_val("rst busy", {31'b0, busy}, 0);
        check_val("rst done", {31'b0, done}, 0);
        start = 1'b1;
        tick();
        check_val("rst_priority busy", {31'b0, busy}, 0);
        reset = 1'b0; start = 1'b0;
        tick();

        run("reg", 1'b0, 16'h0012, 32'h00003000, 5'd5, 32'h0, 32'h0000abcd, got);
        check_str("reg literal", got, SPACES ? "^12@00003000: $5 <= 0000abcd#" : "^12@00003000:$5<=0000abcd#");
        check_val("reg length", got.len(), SPACES ? 29 : 26);
        run("mem", 1'b1, 16'h9999, 32'hdeadbeef, 5'd0, 32'h00000010, 32'hffffffff, got);
        check_str("mem literal", got, SPACES ? "^9999@deadbeef: *00000010 <= ffffffff#" : "^9999@deadbeef:*00000010<=ffffffff#");
        run("edge0", 1'b0, 16'h0000, 32'h0, 5'd31, 32'h0, 32'h0, got);
        check_str("edge0 prefix", got.substr(0, 2), "^0@");
        run("edge_a1", 1'b0, 16'h00a1, 32'h1, 5'd10, 32'h0, 32'h2, got);
        check_str("edge_a1 prefix", got.substr(0, 3), "^91@");

        // start held high: one record, one idle cycle, then the next record begins
        kind = 1'b0; time_bcd = 16'h0012; pc = 32'h00003000; reg_id = 5'd5; addr = 32'h0; data = 32'h0000abcd;
        len = model(1'b0, 16'h0012, 32'h00003000, 5'd5, 32'h0, 32'h0000abcd).len();
        carets = 0; idles = 0; dones = 0;
        start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (char_valid && char == 8'h5e) carets++;
            if (!busy) idles++;
            if (done) dones++;
        end
        start = 1'b0;
        check_val("hold carets", carets, len + 2 <= 40 ? 2 : 1);
        check_val("hold idles", idles, 1);
        check_val("hold dones", dones, 1);
        for (int i = 0; i < 64 && busy; i++) tick();
        check_val("hold drained", {31'b0, busy}, 0);

        // reset on the 10th character aborts the record
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check_val("abort pre valid", {31'b0, char_valid}, 1);
        reset = 1'b1;
        tick();
        check_val("abort char", {24'b0, char}, 0);
        check_val("abort char_valid", {31'b0, char_valid}, 0);
        check_val("abort done", {31'b0, done}, 0);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done || char_valid) dones++;
        end
        check_val("abort quiet", dones, 0);
        run("after_abort", 1'b1, 16'h0305, 32'h12345678, 5'd0, 32'h9abcdef0, 32'h0badf00d, got);

        for (int n = 0; n < 20; n++) begin
            tr = 16'($urandom) >> (4 * $urandom_range(0, 4));
            run($sformatf("rnd%0d", n), 1'($urandom), tr, $urandom, 5'($urandom), $urandom, $urandom, got);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
